// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FUNCT3 access-size codes, controller state encoding and
// small decode helpers for the data memory controller.
// Ports: none (package).
package dmem_pkg;

  // FUNCT3 access-size encodings seen on the load/store path
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Latency counter width: LATENCY is at most 15, so LATENCY-1 fits in 4 bits
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Undefined encodings fall back to a full word
  function automatic size_t f3_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane handling for the data memory.
// Extracts and sign/zero-extends load data, and merges store data into the
// addressed lanes of the current word while preserving the other lanes.
// Ports:
//   i_funct3       access size / signedness
//   i_byte_off     byte offset inside the word (already masked by the caller)
//   i_mem_word     current contents of the addressed word
//   i_store_data   store data, low-order lanes used for B/H
//   o_load_data_c  aligned and extended load result
//   o_store_word_c word to write back for a store
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data_c,
  output logic [31:0] o_store_word_c
);

  size_t       w_size;
  logic        w_sext;
  logic [4:0]  w_shamt;
  logic [15:0] w_shifted;
  logic [31:0] w_lane_mask;

  assign w_size    = f3_size(i_funct3);
  assign w_sext    = f3_signed(i_funct3);
  assign w_shamt   = {i_byte_off, 3'b000};
  assign w_shifted = 16'(i_mem_word >> w_shamt);

  // Load extraction and the lane mask used by the store merge
  always_comb begin
    o_load_data_c = i_mem_word;
    w_lane_mask   = 32'hFFFF_FFFF;
    case (w_size)
      SZ_B: begin
        o_load_data_c = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
        w_lane_mask   = 32'h0000_00FF << w_shamt;
      end
      SZ_H: begin
        o_load_data_c = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
        w_lane_mask   = 32'h0000_FFFF << w_shamt;
      end
      default: ;
    endcase
  end

  assign o_store_word_c = (i_mem_word & ~w_lane_mask) |
                          ((i_store_data << w_shamt) & w_lane_mask);

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: fixed-latency data memory for a CPU load/store port.
// A request accepted in IDLE is latched, held for LATENCY cycles in ACCESS,
// performed on the final ACCESS edge, then followed by a one-cycle DONE.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (flag misaligned H/W accesses
// instead of masking the low address bits).
// Ports:
//   CLK         clock, rising edge
//   RESET       synchronous active-low reset
//   MEM_READ    load request
//   MEM_WRITE   store request (wins when both requests are high)
//   FUNCT3      access size: B, H, W, BU, HU
//   ADDRESS     byte address
//   WRITE_DATA  store data
//   READ_DATA   registered load result
//   BUSYWAIT    combinational CPU stall
//   ERROR       misaligned-access flag
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_rd;
  logic             r_wr;
  logic [2:0]       r_f3;
  logic [IDX_W+1:0] r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_read_data;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_req;
  logic             w_accept;
  logic             w_complete;
  logic             w_misalign;
  logic             w_trap;
  logic             w_do_load;
  logic             w_do_write;
  logic [1:0]       w_off;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_mem_word;
  logic [31:0]      w_load;
  logic [31:0]      w_store_word;
  logic             w_unused;

  assign w_req = MEM_READ | MEM_WRITE;

  // Next-state, counter and stall logic; stall is masked while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    BUSYWAIT    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = ST_ACCESS;
          BUSYWAIT    = RESET;
        end
      end
      ST_ACCESS: begin
        BUSYWAIT = RESET;
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Alignment check and low-address masking for the latched request
  always_comb begin
    w_misalign = 1'b0;
    w_off      = r_addr[1:0];
    case (f3_size(r_f3))
      SZ_H: begin
        w_misalign = r_addr[0];
        w_off      = {r_addr[1], 1'b0};
      end
      SZ_W: begin
        w_misalign = |r_addr[1:0];
        w_off      = 2'b00;
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_error;

  assign w_trap   = w_misalign;
  assign ERROR    = r_error;
  assign w_unused = ^ADDRESS[31:IDX_W+2];

  // ERROR reflects the most recently completed access
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_error <= 1'b0;
    end else if (w_complete) begin
      r_error <= w_misalign;
    end
  end
`else
  assign w_trap   = 1'b0;
  assign ERROR    = 1'b0;
  assign w_unused = ^{ADDRESS[31:IDX_W+2], w_misalign};
`endif

  assign w_idx      = r_addr[IDX_W+1:2];
  assign w_mem_word = r_mem[w_idx];
  assign w_do_write = w_complete & r_wr & ~w_trap;
  assign w_do_load  = w_complete & r_rd & ~r_wr & ~w_trap;
  assign READ_DATA  = r_read_data;

  dmem_lane_align u_lane_align (
    .i_funct3       (r_f3),
    .i_byte_off     (w_off),
    .i_mem_word     (w_mem_word),
    .i_store_data   (r_wdata),
    .o_load_data_c  (w_load),
    .o_store_word_c (w_store_word)
  );

  // Control state and load result
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_complete && w_trap) begin
        r_read_data <= '0;
      end else if (w_do_load) begin
        r_read_data <= w_load;
      end
    end
  end

  // Request snapshot taken at acceptance; later input changes are ignored
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_rd    <= MEM_READ;
      r_wr    <= MEM_WRITE;
      r_f3    <= FUNCT3;
      r_addr  <= ADDRESS[IDX_W+1:0];
      r_wdata <= WRITE_DATA;
    end
  end

  // Storage array is never reset; a reset edge at completion blocks the write
  always_ff @(posedge CLK) begin
    if (RESET && w_do_write) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed load/store sequence for data_memory_ctrl with
// a scoreboard; a monitor compares READ_DATA, ERROR and the stall length each
// time BUSYWAIT falls.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam int unsigned LATENCY     = 4;
  localparam int unsigned DEPTH_WORDS = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        error;

  data_memory_ctrl #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .MEM_READ   (mem_read),
    .MEM_WRITE  (mem_write),
    .FUNCT3     (funct3),
    .ADDRESS    (address),
    .WRITE_DATA (write_data),
    .READ_DATA  (read_data),
    .BUSYWAIT   (busywait),
    .ERROR      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          busy;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_id     = 0;
  logic [31:0] g_rd     = 32'h0;

  task automatic check32(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (access %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
    end
  endtask

  // Monitor: each falling BUSYWAIT retires the oldest expected response
  initial begin : monitor
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (busywait === 1'b1) begin
        busy_run++;
      end else if (busy_run != 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: stall of %0d cycles with nothing outstanding", busy_run);
        end else begin
          e = sb_q.pop_front();
          check32("read_data", e.id, read_data, e.rd);
          check32("error", e.id, 32'(error), 32'(e.err));
          check32("busy_cycles", e.id, 32'(busy_run), 32'(e.busy));
        end
        busy_run = 0;
      end
    end
  end

  // One CPU access; called at posedge+1, returns at posedge+1 with the port idle
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input bit abort);
    exp_t e;
    int   cyc;
    e.rd   = exp_rd;
    e.err  = exp_err;
    e.busy = abort ? 2 : int'(LATENCY) + 1;
    e.id   = n_id;
    n_id++;
    sb_q.push_back(e);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    address    = addr;
    write_data = wd;
    @(posedge clk); #1;
    funct3     = ~f3;
    address    = ~addr;
    write_data = ~wd;
    if (abort) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      cyc = 0;
      while (busywait === 1'b1 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (busywait !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_timeout (access %0d): BUSYWAIT still %b after %0d cycles", e.id, busywait, cyc);
      end
      // keep the request asserted through DONE, which must ignore it
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp, input logic err);
    access(1'b1, 1'b0, f3, addr, 32'h0, exp, err, 1'b0);
    g_rd = exp;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic err);
    logic [31:0] exp;
    exp = err ? 32'h0 : g_rd;
    access(1'b0, 1'b1, f3, addr, wd, exp, err, 1'b0);
    g_rd = exp;
  endtask

  initial begin : stimulus
    rst_n      = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = F3_W;
    address    = 32'h10;
    write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_busywait", -1, 32'(busywait), 32'h0);
    check32("reset_read_data", -1, read_data, 32'h0);
    check32("reset_error", -1, 32'(error), 32'h0);
    mem_read = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    st(F3_W,  32'h10, 32'hDEADBEEF, 1'b0);
    ld(F3_W,  32'h10, 32'hDEADBEEF, 1'b0);
    ld(F3_B,  32'h13, 32'hFFFFFFDE, 1'b0);
    ld(F3_BU, 32'h13, 32'h000000DE, 1'b0);
    ld(F3_HU, 32'h12, 32'h0000DEAD, 1'b0);
    ld(F3_H,  32'h10, 32'hFFFFBEEF, 1'b0);
    ld(F3_B,  32'h11, 32'hFFFFFFBE, 1'b0);
    ld(F3_HU, 32'h10, 32'h0000BEEF, 1'b0);

    st(F3_B,  32'h11, 32'hFFFFFF55, 1'b0);
    ld(F3_W,  32'h10, 32'hDEAD55EF, 1'b0);
    st(F3_H,  32'h12, 32'hABCD1234, 1'b0);
    ld(F3_W,  32'h10, 32'h123455EF, 1'b0);

    // read and write together: store only, READ_DATA untouched
    access(1'b1, 1'b1, F3_W, 32'h14, 32'h0BADF00D, g_rd, 1'b0, 1'b0);
    ld(F3_W,  32'h14, 32'h0BADF00D, 1'b0);

    // reset in the second ACCESS cycle aborts the store
    st(F3_W,  32'h20, 32'hCAFEF00D, 1'b0);
    ld(F3_W,  32'h20, 32'hCAFEF00D, 1'b0);
    access(1'b0, 1'b1, F3_W, 32'h20, 32'h12345678, g_rd, 1'b0, 1'b1);
    check32("abort_read_data", -1, read_data, 32'h0);
    check32("abort_error", -1, 32'(error), 32'h0);
    g_rd = 32'h0;
    ld(F3_W,  32'h20, 32'hCAFEF00D, 1'b0);

    // address wrap and undefined FUNCT3 treated as a word
    st(F3_W,  32'h400, 32'hA5A5A5A5, 1'b0);
    ld(F3_W,  32'h0,   32'hA5A5A5A5, 1'b0);
    ld(3'b011, 32'h10, 32'h123455EF, 1'b0);

    // misaligned accesses: trapped or masked depending on the build
    st(F3_W,  32'h21, 32'h11223344, TRAP);
    ld(F3_W,  32'h20, TRAP ? 32'hCAFEF00D : 32'h11223344, 1'b0);
    ld(F3_H,  32'h11, TRAP ? 32'h0 : 32'h000055EF, TRAP);
    ld(F3_BU, 32'h11, 32'h00000055, 1'b0);
    ld(F3_W,  32'h13, TRAP ? 32'h0 : 32'h123455EF, TRAP);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_drained", -1, 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
